// File: rtl/irrigation_if.sv
// Irrigation scheduler bus: requests and enables in, valve/pump commands out.
// The scheduler is the slave; whoever drives sensors and enable is the master.
interface irrigation_if #(
   parameter int N = 2
);
   localparam int ZW = $clog2(N);

   logic          enable;
   logic [N-1:0]  U;
   logic          fault_clr;
   logic [N-1:0]  valve;
   logic          pump;
   logic [ZW-1:0] zone;
   logic          busy;
   logic [N-1:0]  fault;

   modport master (
      output enable, U, fault_clr,
      input  valve, pump, zone, busy, fault
   );

   modport slave (
      input  enable, U, fault_clr,
      output valve, pump, zone, busy, fault
   );
endinterface

// File: rtl/irrigation_scheduler.sv
// Shared-pump irrigation sequencer: round-robin zone grants with settle gaps,
// bounded pump runs and sticky per-zone timeout faults.
module irrigation_scheduler #(
   parameter int N      = 2,
   parameter int SETTLE = 2,
   parameter int MIN_ON = 4,
   parameter int MAX_ON = 10
) (
   input logic        clk,
   input logic        reset,
   irrigation_if.slave bus
);
   localparam int ZW = $clog2(N);
   localparam int CW = $clog2(MAX_ON + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_OPEN  = 2'd1;
   localparam logic [1:0] S_WATER = 2'd2;
   localparam logic [1:0] S_CLOSE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [ZW-1:0] zone_q, zone_d;
   logic [ZW-1:0] last_q, last_d;
   logic [N-1:0]  fault_q, fault_d;
   logic [N-1:0]  elig;
   logic [ZW-1:0] pick, idx;
   logic          dry;

   assign elig    = bus.U & ~fault_q;
   assign dry     = bus.U[zone_q];
   assign cnt_inc = (cnt_q == CW'(MAX_ON)) ? cnt_q : cnt_q + CW'(1);

   // Descending scan so the closest zone after last wins.
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int k = N; k >= 1; k--) begin
         idx = ZW'((int'(last_q) + k) % N);
         if (elig[idx]) pick = idx;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      zone_d  = zone_q;
      last_d  = last_q;
      fault_d = bus.fault_clr ? '0 : fault_q;
      case (state_q)
         S_IDLE: begin
            if (bus.enable && |elig) begin
               state_d = S_OPEN;
               zone_d  = pick;
               cnt_d   = '0;
            end
         end
         S_OPEN: begin
            if (!bus.enable) begin
               state_d = S_CLOSE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = S_WATER;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WATER: begin
            if (!bus.enable) begin
               state_d = S_CLOSE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(MAX_ON - 1)) begin
               state_d = S_CLOSE;
               cnt_d   = '0;
               if (dry) fault_d[zone_q] = 1'b1;
            end else if (cnt_q >= CW'(MIN_ON - 1) && !dry) begin
               state_d = S_CLOSE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_CLOSE: begin
            if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = S_IDLE;
               last_d  = zone_q;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         zone_q  <= '0;
         last_q  <= ZW'(N - 1);
         fault_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         zone_q  <= zone_d;
         last_q  <= last_d;
         fault_q <= fault_d;
      end
   end

   assign bus.valve = (state_q == S_IDLE) ? '0 : (N'(1) << zone_q);
   assign bus.pump  = (state_q == S_WATER);
   assign bus.busy  = (state_q != S_IDLE);
   assign bus.zone  = (state_q == S_IDLE) ? '0 : zone_q;
   assign bus.fault = fault_q;
endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler: a cycle table for reset and a
// single run, then hand-written round-robin, timeout, abort and reset cases.
module tb_irrigation_scheduler;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   irrigation_if #(.N(2)) bus ();

   irrigation_scheduler #(
      .N(2), .SETTLE(2), .MIN_ON(4), .MAX_ON(10)
   ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] u;
      logic       fc;
      logic [1:0] valve;
      logic       pump;
      logic       zone;
      logic       busy;
      logic [1:0] fault;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic [1:0] u,
                      input logic fc);
      rst           = r;
      bus.enable    = e;
      bus.U         = u;
      bus.fault_clr = fc;
      @(posedge clk);
      #1;
      if (bus.pump) chk("pump_needs_valve", 32'(bus.valve != 2'b00), 1);
      if (!bus.busy) chk("idle_zone", 32'(bus.zone), 0);
   endtask

   task automatic grant(input logic [1:0] u, input logic ez,
                        input string nm);
      int n = 0;
      while (!bus.busy && n < 8) begin
         cyc(1'b0, 1'b1, u, 1'b0);
         n++;
      end
      chk({nm, "_busy"}, 32'(bus.busy), 1);
      chk({nm, "_zone"}, 32'(bus.zone), 32'(ez));
   endtask

   task automatic finish_run(input logic [1:0] u, output int pc);
      int n = 0;
      pc = 0;
      while (bus.busy && n < 40) begin
         if (bus.pump) pc++;
         cyc(1'b0, 1'b1, u, 1'b0);
         n++;
      end
      chk("run_ended", 32'(bus.busy), 0);
   endtask

   initial begin
      int pc;
      int n;
      logic [1:0] u;

      // Reset with U=11, grant zone 0, zone goes wet from t+3.
      tv[0]  = '{1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
      tv[1]  = '{1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
      tv[2]  = '{1'b0, 1'b1, 2'b11, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00};
      tv[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00};
      tv[4]  = '{1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00};
      tv[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00};
      tv[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00};
      tv[7]  = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00};
      tv[8]  = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00};
      tv[9]  = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00};
      tv[10] = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
      tv[11] = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};

      for (int i = 0; i < 12; i++) begin
         cyc(tv[i].rst, tv[i].en, tv[i].u, tv[i].fc);
         chk($sformatf("tv%0d_valve", i), 32'(bus.valve), 32'(tv[i].valve));
         chk($sformatf("tv%0d_pump", i), 32'(bus.pump), 32'(tv[i].pump));
         chk($sformatf("tv%0d_zone", i), 32'(bus.zone), 32'(tv[i].zone));
         chk($sformatf("tv%0d_busy", i), 32'(bus.busy), 32'(tv[i].busy));
         chk($sformatf("tv%0d_fault", i), 32'(bus.fault), 32'(tv[i].fault));
      end

      // Round-robin from a fresh reset: 0, 1, 0, 1.
      cyc(1'b1, 1'b1, 2'b00, 1'b0);
      cyc(1'b1, 1'b1, 2'b00, 1'b0);
      for (int g = 0; g < 4; g++) begin
         grant(2'b11, 1'(g % 2), $sformatf("rr%0d", g));
         u  = 2'b11;
         pc = 0;
         n  = 0;
         while (bus.busy && n < 40) begin
            chk($sformatf("rr%0d_valve", g), 32'(bus.valve),
                32'(2'b01 << (g % 2)));
            if (bus.pump) pc++;
            if (pc == 4) u = 2'b11 & ~(2'b01 << (g % 2));
            cyc(1'b0, 1'b1, u, 1'b0);
            n++;
         end
         chk($sformatf("rr%0d_pumpcyc", g), 32'(pc), 4);
         chk($sformatf("rr%0d_gap_valve", g), 32'(bus.valve), 0);
      end

      // Timeout on a stuck-dry zone 1.
      grant(2'b10, 1'b1, "to");
      finish_run(2'b10, pc);
      chk("to_pumpcyc", 32'(pc), 10);
      chk("to_fault", 32'(bus.fault), 32'(2'b10));
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1, 2'b10, 1'b0);
         chk("to_no_regrant", 32'(bus.busy), 0);
      end
      cyc(1'b0, 1'b1, 2'b10, 1'b1);
      chk("fclr_fault", 32'(bus.fault), 0);
      chk("fclr_not_yet", 32'(bus.busy), 0);
      cyc(1'b0, 1'b1, 2'b10, 1'b0);
      chk("fclr_regrant", 32'(bus.busy), 1);
      chk("fclr_zone", 32'(bus.zone), 1);

      // Abort that regrant on its 2nd WATER cycle.
      cyc(1'b0, 1'b1, 2'b10, 1'b0);
      cyc(1'b0, 1'b1, 2'b10, 1'b0);
      chk("ab_water1", 32'(bus.pump), 1);
      cyc(1'b0, 1'b1, 2'b10, 1'b0);
      chk("ab_water2", 32'(bus.pump), 1);
      cyc(1'b0, 1'b0, 2'b10, 1'b0);
      chk("ab_pump_off", 32'(bus.pump), 0);
      chk("ab_valve1", 32'(bus.valve), 32'(2'b10));
      cyc(1'b0, 1'b0, 2'b10, 1'b0);
      chk("ab_valve2", 32'(bus.valve), 32'(2'b10));
      cyc(1'b0, 1'b0, 2'b10, 1'b0);
      chk("ab_idle_valve", 32'(bus.valve), 0);
      chk("ab_idle_busy", 32'(bus.busy), 0);
      chk("ab_fault", 32'(bus.fault), 0);
      cyc(1'b0, 1'b0, 2'b10, 1'b0);
      chk("ab_disabled_idle", 32'(bus.busy), 0);

      // Fault zone 0, then reset during WATER of zone 1.
      grant(2'b01, 1'b0, "f0");
      finish_run(2'b01, pc);
      chk("f0_pumpcyc", 32'(pc), 10);
      chk("f0_fault", 32'(bus.fault), 32'(2'b01));
      grant(2'b11, 1'b1, "rm");
      cyc(1'b0, 1'b1, 2'b11, 1'b0);
      cyc(1'b0, 1'b1, 2'b11, 1'b0);
      chk("rm_water", 32'(bus.pump), 1);
      cyc(1'b1, 1'b1, 2'b11, 1'b0);
      chk("rm_pump", 32'(bus.pump), 0);
      chk("rm_valve", 32'(bus.valve), 0);
      chk("rm_fault", 32'(bus.fault), 0);
      chk("rm_busy", 32'(bus.busy), 0);
      cyc(1'b0, 1'b1, 2'b11, 1'b0);
      chk("rm_next_busy", 32'(bus.busy), 1);
      chk("rm_next_zone", 32'(bus.zone), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
